// File: rtl/punc_control_unit_pkg.sv
// punc_control_unit_pkg: opcodes, FSM states, ALU codes and datapath select encodings shared by the PUnC controller.
package punc_control_unit_pkg;
  localparam logic [3:0] OP_BR = 4'b0000, OP_ADD = 4'b0001, OP_LD = 4'b0010, OP_ST = 4'b0011;
  localparam logic [3:0] OP_JSR = 4'b0100, OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR = 4'b0111;
  localparam logic [3:0] OP_RTI = 4'b1000, OP_NOT = 4'b1001, OP_LDI = 4'b1010, OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100, OP_RES = 4'b1101, OP_LEA = 4'b1110, OP_TRAP = 4'b1111;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_EXEC2, S_HALT} state_t;
  localparam logic [4:0] ALU_ADD = 5'd0, ALU_AND = 5'd1, ALU_ADDI = 5'd2, ALU_ANDI = 5'd3;
  localparam logic [4:0] ALU_NOT = 5'd4, ALU_BR = 5'd5, ALU_JMP_RET = 5'd6, ALU_JSR = 5'd7;
  localparam logic [4:0] ALU_JSRR = 5'd8, ALU_LD = 5'd9, ALU_LDR = 5'd10, ALU_LEA = 5'd11;
  localparam logic [4:0] ALU_ST = 5'd12, ALU_STR = 5'd13, ALU_LDI1 = 5'd14, ALU_LDI2 = 5'd15;
  localparam logic [4:0] ALU_STI1 = 5'd16;
  localparam logic [1:0] MEM_R_PC = 2'd0, MEM_R_CTRL = 2'd1, MEM_R_ALU = 2'd2;
  localparam logic [1:0] MEM_W_ADDR_CTRL = 2'd0, MEM_W_ADDR_ALU = 2'd1, MEM_W_ADDR_SELF = 2'd2;
  localparam logic [1:0] MEM_W_DATA_CTRL = 2'd0, MEM_W_DATA_R0 = 2'd1;
  localparam logic [1:0] RF_W_CTRL = 2'd0, RF_W_ALU = 2'd1, RF_W_MEM = 2'd2, RF_W_PC = 2'd3;
  function automatic logic [3:0] f_op(input logic [15:0] i);
    return i[15:12];
  endfunction
  function automatic logic [2:0] f_dr(input logic [15:0] i);
    return i[11:9];
  endfunction
  function automatic logic [2:0] f_sr1(input logic [15:0] i);
    return i[8:6];
  endfunction
  function automatic logic [2:0] f_sr2(input logic [15:0] i);
    return i[2:0];
  endfunction
endpackage

// File: rtl/punc_control_unit.sv
// punc_control_unit: fetch/decode/execute FSM generating every PUnC LC3 datapath strobe and select.
module punc_control_unit
  import punc_control_unit_pkg::*;
#(
  parameter bit HALT_ON_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc,
  input  logic [15:0] ir,
  output logic        pc_inc,
  output logic        pc_clr,
  output logic        pc_w_en,
  output logic        ir_w_en,
  output logic [15:0] mem_r_addr_ctrl,
  output logic [1:0]  mem_r_s,
  output logic [1:0]  mem_w_addr_s,
  output logic [1:0]  mem_w_data_s,
  output logic        mem_w_en,
  output logic [4:0]  alu_s,
  output logic        rf_w_en,
  output logic [1:0]  rf_w_s,
  output logic [2:0]  rf_w_addr,
  output logic [2:0]  rf_r0_addr,
  output logic [2:0]  rf_r1_addr,
  output logic [15:0] rf_w_data_ctrl,
  output logic        status_w_en,
  output logic        halted
);
  state_t r_state, w_next;
  logic [3:0] w_op;
  logic [2:0] w_dr, w_sr1, w_sr2;
  assign w_op  = f_op(ir);
  assign w_dr  = f_dr(ir);
  assign w_sr1 = f_sr1(ir);
  assign w_sr2 = f_sr2(ir);
  always_ff @(posedge clk)
    if (rst) r_state <= S_FETCH;
    else r_state <= w_next;
  // rst overrides every state combinationally so no strobe leaks out in the reset cycle
  always_comb begin
    pc_inc = 1'b0;
    pc_clr = 1'b0;
    pc_w_en = 1'b0;
    ir_w_en = 1'b0;
    mem_r_addr_ctrl = 16'h0;
    mem_r_s = MEM_R_PC;
    mem_w_addr_s = MEM_W_ADDR_CTRL;
    mem_w_data_s = MEM_W_DATA_CTRL;
    mem_w_en = 1'b0;
    alu_s = ALU_ADD;
    rf_w_en = 1'b0;
    rf_w_s = RF_W_CTRL;
    rf_w_addr = 3'd0;
    rf_r0_addr = 3'd0;
    rf_r1_addr = 3'd0;
    rf_w_data_ctrl = 16'h0;
    status_w_en = 1'b0;
    halted = 1'b0;
    w_next = r_state;
    if (rst) begin
      pc_clr = 1'b1;
      w_next = S_FETCH;
    end else case (r_state)
      S_FETCH: begin
        mem_r_s = MEM_R_CTRL;
        mem_r_addr_ctrl = pc;
        ir_w_en = 1'b1;
        pc_inc = 1'b1;
        w_next = S_DECODE;
      end
      S_DECODE: w_next = (w_op == OP_TRAP && HALT_ON_TRAP) ? S_HALT : S_EXEC;
      S_EXEC: begin
        w_next = (w_op == OP_LDI || w_op == OP_STI) ? S_EXEC2 : S_FETCH;
        case (w_op)
          OP_ADD, OP_AND: begin
            alu_s = (w_op == OP_ADD) ? (ir[5] ? ALU_ADDI : ALU_ADD) : (ir[5] ? ALU_ANDI : ALU_AND);
            rf_r0_addr = w_sr1;
            rf_r1_addr = w_sr2;
            rf_w_addr = w_dr;
            rf_w_s = RF_W_ALU;
            rf_w_en = 1'b1;
            status_w_en = 1'b1;
          end
          OP_NOT: begin
            alu_s = ALU_NOT;
            rf_r0_addr = w_sr1;
            rf_w_addr = w_dr;
            rf_w_s = RF_W_ALU;
            rf_w_en = 1'b1;
            status_w_en = 1'b1;
          end
          OP_BR: begin
            alu_s = ALU_BR;
            pc_w_en = 1'b1;
          end
          OP_JMP: begin
            alu_s = ALU_JMP_RET;
            rf_r0_addr = w_sr1;
            pc_w_en = 1'b1;
          end
          // R7 and PC update together; the datapath reads the old R7 for JSRR R7
          OP_JSR: begin
            alu_s = ir[11] ? ALU_JSR : ALU_JSRR;
            rf_r0_addr = ir[11] ? 3'd0 : w_sr1;
            rf_w_addr = 3'd7;
            rf_w_s = RF_W_PC;
            rf_w_en = 1'b1;
            pc_w_en = 1'b1;
          end
          OP_LD, OP_LDR: begin
            alu_s = (w_op == OP_LD) ? ALU_LD : ALU_LDR;
            rf_r0_addr = (w_op == OP_LD) ? 3'd0 : w_sr1;
            mem_r_s = MEM_R_ALU;
            rf_w_addr = w_dr;
            rf_w_s = RF_W_MEM;
            rf_w_en = 1'b1;
            status_w_en = 1'b1;
          end
          OP_LEA: begin
            alu_s = ALU_LEA;
            rf_w_addr = w_dr;
            rf_w_s = RF_W_ALU;
            rf_w_en = 1'b1;
            status_w_en = 1'b1;
          end
          OP_ST, OP_STR: begin
            alu_s = (w_op == OP_ST) ? ALU_ST : ALU_STR;
            rf_r1_addr = (w_op == OP_ST) ? 3'd0 : w_sr1;
            rf_r0_addr = w_dr;
            mem_w_addr_s = MEM_W_ADDR_ALU;
            mem_w_data_s = MEM_W_DATA_R0;
            mem_w_en = 1'b1;
          end
          OP_LDI: begin
            alu_s = ALU_LDI1;
            mem_r_s = MEM_R_ALU;
            rf_w_s = RF_W_MEM;
            rf_w_addr = w_dr;
            rf_w_en = 1'b1;
          end
          OP_STI: begin
            alu_s = ALU_STI1;
            mem_r_s = MEM_R_ALU;
            mem_w_addr_s = MEM_W_ADDR_SELF;
            mem_w_data_s = MEM_W_DATA_R0;
            rf_r0_addr = w_dr;
            mem_w_en = 1'b1;
          end
          default: ;
        endcase
      end
      S_EXEC2: begin
        w_next = S_FETCH;
        if (w_op == OP_LDI) begin
          alu_s = ALU_LDI2;
          rf_r0_addr = w_dr;
          mem_r_s = MEM_R_ALU;
          rf_w_s = RF_W_MEM;
          rf_w_addr = w_dr;
          rf_w_en = 1'b1;
          status_w_en = 1'b1;
        end
      end
      S_HALT: halted = 1'b1;
      default: w_next = S_FETCH;
    endcase
  end
endmodule
